// File: rtl/ats_eligibility_scheduler_if.sv
// Descriptor handshake bundle for ats_eligibility_scheduler.
// The s_desc_* signals carry frames in; the m_desc_* signals release them to transmit selection.
interface ats_eligibility_scheduler_if #(
    parameter int unsigned TIMESTAMP_WIDTH    = 72,
    parameter int unsigned FRAME_LENGTH_WIDTH = 16
);
    logic [FRAME_LENGTH_WIDTH-1:0] s_desc_len;
    logic [TIMESTAMP_WIDTH-1:0]    s_desc_arrival;
    logic                          s_desc_valid;
    logic                          s_desc_ready;

    logic [FRAME_LENGTH_WIDTH-1:0] m_desc_len;
    logic [TIMESTAMP_WIDTH-1:0]    m_desc_elig;
    logic                          m_desc_drop;
    logic                          m_desc_valid;
    logic                          m_desc_ready;

    modport master (
        output s_desc_len, s_desc_arrival, s_desc_valid, m_desc_ready,
        input  s_desc_ready, m_desc_len, m_desc_elig, m_desc_drop, m_desc_valid
    );

    modport slave (
        input  s_desc_len, s_desc_arrival, s_desc_valid, m_desc_ready,
        output s_desc_ready, m_desc_len, m_desc_elig, m_desc_drop, m_desc_valid
    );
endinterface

// File: rtl/ats_eligibility_scheduler.sv
// Per-stream 802.1Qcr token-bucket eligibility scheduler: computes eligibility and holds each descriptor until the timer reaches it.
// Define ATS_SCHEDULER_DROP_EN to enable the max-residence drop check.
module ats_eligibility_scheduler #(
    parameter int unsigned TIMESTAMP_WIDTH    = 72,
    parameter int unsigned FRAME_LENGTH_WIDTH = 16,
    parameter int unsigned RATE_WIDTH         = 24,
    parameter int unsigned BURST_WIDTH        = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TIMESTAMP_WIDTH-1:0] ats_scheduler_timer,
    input  logic [RATE_WIDTH-1:0]      cfg_ps_per_byte,
    input  logic [BURST_WIDTH-1:0]     cfg_burst_bytes,
    input  logic [TIMESTAMP_WIDTH-1:0] cfg_max_residence,
    ats_eligibility_scheduler_if.slave desc
);
    localparam int unsigned LEN_PROD_W   = FRAME_LENGTH_WIDTH + RATE_WIDTH;
    localparam int unsigned BURST_PROD_W = BURST_WIDTH + RATE_WIDTH;

    typedef enum logic [2:0] {IDLE, MUL, ELIG, DECIDE, WAIT, OUT} state_t;

    state_t state_q, state_d;

    logic [TIMESTAMP_WIDTH-1:0]    bucket_empty_time;
    logic [TIMESTAMP_WIDTH-1:0]    group_elig_time;
    logic [FRAME_LENGTH_WIDTH-1:0] len_q;
    logic [TIMESTAMP_WIDTH-1:0]    arrival_q;
    logic [RATE_WIDTH-1:0]         rate_q;
    logic [BURST_WIDTH-1:0]        burst_q;
    logic [TIMESTAMP_WIDTH-1:0]    len_dur_q;
    logic [TIMESTAMP_WIDTH-1:0]    e2f_dur_q;
    logic [TIMESTAMP_WIDTH-1:0]    sched_q;
    logic [TIMESTAMP_WIDTH-1:0]    full_q;
    logic [TIMESTAMP_WIDTH-1:0]    elig_q;

    logic [LEN_PROD_W-1:0]         len_prod;
    logic [BURST_PROD_W-1:0]       burst_prod;
    logic [TIMESTAMP_WIDTH-1:0]    sched_c;
    logic [TIMESTAMP_WIDTH-1:0]    elig_c;
    logic                          accept;
    logic                          drop_now;

    assign accept     = (state_q == IDLE) && desc.s_desc_valid;
    assign len_prod   = {{RATE_WIDTH{1'b0}}, len_q} * {{FRAME_LENGTH_WIDTH{1'b0}}, rate_q};
    assign burst_prod = {{RATE_WIDTH{1'b0}}, burst_q} * {{BURST_WIDTH{1'b0}}, rate_q};
    assign sched_c    = bucket_empty_time + len_dur_q;

    // A zero rate disables the bucket term so elig is just max(arrival, group).
    always_comb begin
        elig_c = (arrival_q > group_elig_time) ? arrival_q : group_elig_time;
        if ((rate_q != '0) && (sched_c > elig_c))
            elig_c = sched_c;
    end

`ifdef ATS_SCHEDULER_DROP_EN
    logic [TIMESTAMP_WIDTH-1:0] max_res_q;
    logic                       drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            max_res_q <= '0;
            drop_q    <= 1'b0;
        end else if (accept) begin
            max_res_q <= cfg_max_residence;
            drop_q    <= 1'b0;
        end else if ((state_q == DECIDE) && drop_now) begin
            drop_q    <= 1'b1;
        end
    end

    assign drop_now         = elig_q > (arrival_q + max_res_q);
    assign desc.m_desc_drop = drop_q;
`else
    logic unused_max_res;
    assign unused_max_res   = ^cfg_max_residence;
    assign drop_now         = 1'b0;
    assign desc.m_desc_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (desc.s_desc_valid) state_d = MUL;
            MUL:     state_d = ELIG;
            ELIG:    state_d = DECIDE;
            DECIDE:  state_d = drop_now ? OUT : WAIT;
            WAIT:    if (ats_scheduler_timer >= elig_q) state_d = OUT;
            OUT:     if (desc.m_desc_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bucket_empty_time <= '0;
            group_elig_time   <= '0;
            len_q             <= '0;
            arrival_q         <= '0;
            rate_q            <= '0;
            burst_q           <= '0;
            len_dur_q         <= '0;
            e2f_dur_q         <= '0;
            sched_q           <= '0;
            full_q            <= '0;
            elig_q            <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    len_q     <= desc.s_desc_len;
                    arrival_q <= desc.s_desc_arrival;
                    rate_q    <= cfg_ps_per_byte;
                    burst_q   <= cfg_burst_bytes;
                end
                MUL: begin
                    len_dur_q <= {{(TIMESTAMP_WIDTH-LEN_PROD_W){1'b0}}, len_prod};
                    e2f_dur_q <= {{(TIMESTAMP_WIDTH-BURST_PROD_W){1'b0}}, burst_prod};
                end
                ELIG: begin
                    sched_q <= sched_c;
                    full_q  <= bucket_empty_time + e2f_dur_q;
                    elig_q  <= elig_c;
                end
                DECIDE: if (!drop_now) begin
                    group_elig_time <= elig_q;
                    // Past bucket_full the bucket overflowed; carry the excess into the empty time.
                    if (elig_q < full_q) bucket_empty_time <= sched_q;
                    else                 bucket_empty_time <= sched_q + elig_q - full_q;
                end
                default: ;
            endcase
        end
    end

    assign desc.s_desc_ready = (state_q == IDLE) && !rst;
    assign desc.m_desc_valid = (state_q == OUT);
    assign desc.m_desc_len   = len_q;
    assign desc.m_desc_elig  = elig_q;
endmodule

// File: tb/tb_ats_eligibility_scheduler.sv
// Directed bench for ats_eligibility_scheduler: 8000 ps/byte, 1500 B burst, timer +8000 ps per cycle.
module tb_ats_eligibility_scheduler;
    localparam int unsigned TW = 72;
    localparam int unsigned FW = 16;
    localparam int unsigned RW = 24;
    localparam int unsigned BW = 24;

    logic           clk = 1'b0;
    logic           rst;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  timer_base = '0;
    longint unsigned cyc = 0;
    logic [RW-1:0]  cfg_ps_per_byte;
    logic [BW-1:0]  cfg_burst_bytes;
    logic [TW-1:0]  cfg_max_residence;
    int n_cmp = 0;
    int n_bad = 0;

    ats_eligibility_scheduler_if #(.TIMESTAMP_WIDTH(TW), .FRAME_LENGTH_WIDTH(FW)) dif ();

    ats_eligibility_scheduler #(
        .TIMESTAMP_WIDTH(TW), .FRAME_LENGTH_WIDTH(FW), .RATE_WIDTH(RW), .BURST_WIDTH(BW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ats_scheduler_timer(timer),
        .cfg_ps_per_byte    (cfg_ps_per_byte),
        .cfg_burst_bytes    (cfg_burst_bytes),
        .cfg_max_residence  (cfg_max_residence),
        .desc               (dif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign timer = timer_base + 72'(cyc) * 72'd8000;

    task automatic set_timer(input logic [TW-1:0] v);
        timer_base = v - 72'(cyc) * 72'd8000;
    endtask

    // Called at a negedge; returns at the negedge right after the input handshake (cycle T+1).
    task automatic send_desc(input logic [FW-1:0] len, input logic [TW-1:0] arr);
        int unsigned w = 0;
        cfg_ps_per_byte = 24'd8000;
        cfg_burst_bytes = 24'd1500;
        while (dif.s_desc_ready !== 1'b1 && w < 100) begin
            @(posedge clk); @(negedge clk); w++;
        end
        n_cmp++;
        if (dif.s_desc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: s_desc_ready=%b after %0d cycles, expected 1", dif.s_desc_ready, w);
        end
        dif.s_desc_len     = len;
        dif.s_desc_arrival = arr;
        dif.s_desc_valid   = 1'b1;
        @(posedge clk); @(negedge clk);
        dif.s_desc_valid   = 1'b0;
        dif.s_desc_len     = '1;
        dif.s_desc_arrival = '1;
        cfg_ps_per_byte    = 24'd1;
        cfg_burst_bytes    = 24'd1;
    endtask

    task automatic wait_valid(output int unsigned lat, output logic [TW-1:0] t_prev);
        bit seen = 1'b0;
        lat = 1;
        t_prev = '0;
        for (int i = 0; i < 400; i++) begin
            if (dif.m_desc_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            t_prev = timer;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL wait_valid: m_desc_valid not seen within %0d cycles, expected 1", lat);
        end
    endtask

    task automatic pop_out();
        dif.m_desc_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        dif.m_desc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dif.s_desc_valid = 1'b1;
        dif.s_desc_len = 16'd64;
        dif.s_desc_arrival = 72'd5;
        dif.m_desc_ready = 1'b0;
        cfg_ps_per_byte = 24'd8000;
        cfg_burst_bytes = 24'd1500;
        cfg_max_residence = 72'd800_000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dif.s_desc_ready !== 1'b0 || dif.m_desc_valid !== 1'b0 || dif.m_desc_drop !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: ready=%b valid=%b drop=%b, expected 0 0 0",
                     dif.s_desc_ready, dif.m_desc_valid, dif.m_desc_drop);
        end
        n_cmp++;
        if (dif.m_desc_len !== '0 || dif.m_desc_elig !== '0) begin
            n_bad++;
            $display("FAIL reset_data: len=%0d elig=%0d, expected 0 0", dif.m_desc_len, dif.m_desc_elig);
        end
        rst = 1'b0;
        dif.s_desc_valid = 1'b0;
        #1;
        n_cmp++;
        if (dif.s_desc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: s_desc_ready=%b, expected 1", dif.s_desc_ready);
        end
        n_cmp++;
        if (dut.bucket_empty_time !== '0 || dut.group_elig_time !== '0) begin
            n_bad++;
            $display("FAIL reset_state: bucket_empty=%0d group=%0d, expected 0 0",
                     dut.bucket_empty_time, dut.group_elig_time);
        end
        @(negedge clk);
    endtask

    task automatic test_min_latency();
        int unsigned lat;
        logic [TW-1:0] tp;
        set_timer(72'd150_000_000);
        send_desc(16'd64, 72'd100_000_000);
        wait_valid(lat, tp);
        n_cmp++;
        if (lat != 5) begin
            n_bad++;
            $display("FAIL min_latency: valid at T+%0d, expected T+5", lat);
        end
        n_cmp++;
        if (dif.m_desc_elig !== 72'd100_000_000 || dif.m_desc_drop !== 1'b0 || dif.m_desc_len !== 16'd64) begin
            n_bad++;
            $display("FAIL d1_out: elig=%0d drop=%b len=%0d, expected 100000000 0 64",
                     dif.m_desc_elig, dif.m_desc_drop, dif.m_desc_len);
        end
        n_cmp++;
        if (dut.bucket_empty_time !== 72'd88_512_000) begin
            n_bad++;
            $display("FAIL d1_bucket: bucket_empty=%0d, expected 88512000", dut.bucket_empty_time);
        end
        pop_out();
        n_cmp++;
        if (dif.m_desc_valid !== 1'b0 || dif.s_desc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL d1_pop: valid=%b ready=%b, expected 0 1", dif.m_desc_valid, dif.s_desc_ready);
        end
    endtask

    task automatic test_wait_release();
        int unsigned lat;
        logic [TW-1:0] tp;
        set_timer(72'd100_400_000);
        send_desc(16'd1500, 72'd100_000_000);
        wait_valid(lat, tp);
        n_cmp++;
        if (dif.m_desc_elig !== 72'd100_512_000 || dif.m_desc_drop !== 1'b0 || dif.m_desc_len !== 16'd1500) begin
            n_bad++;
            $display("FAIL d2_out: elig=%0d drop=%b len=%0d, expected 100512000 0 1500",
                     dif.m_desc_elig, dif.m_desc_drop, dif.m_desc_len);
        end
        n_cmp++;
        if (tp !== 72'd100_512_000 || lat != 15) begin
            n_bad++;
            $display("FAIL d2_release: prior-cycle timer=%0d lat=%0d, expected 100512000 15", tp, lat);
        end
        n_cmp++;
        if (dut.bucket_empty_time !== 72'd100_512_000) begin
            n_bad++;
            $display("FAIL d2_bucket: bucket_empty=%0d, expected 100512000", dut.bucket_empty_time);
        end
        pop_out();
    endtask

    task automatic test_third_desc();
        int unsigned lat;
        logic [TW-1:0] tp;
        int unsigned exp_lat;
        logic exp_drop;
        logic [TW-1:0] exp_bucket;
`ifdef ATS_SCHEDULER_DROP_EN
        exp_lat = 4; exp_drop = 1'b1; exp_bucket = 72'd100_512_000;
`else
        exp_lat = 5; exp_drop = 1'b0; exp_bucket = 72'd101_024_000;
`endif
        set_timer(72'd150_000_000);
        send_desc(16'd64, 72'd100_000_000);
        wait_valid(lat, tp);
        n_cmp++;
        if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL d3_latency: valid at T+%0d, expected T+%0d", lat, exp_lat);
        end
        n_cmp++;
        if (dif.m_desc_elig !== 72'd101_024_000 || dif.m_desc_drop !== exp_drop) begin
            n_bad++;
            $display("FAIL d3_out: elig=%0d drop=%b, expected 101024000 %b",
                     dif.m_desc_elig, dif.m_desc_drop, exp_drop);
        end
        n_cmp++;
        if (dut.bucket_empty_time !== exp_bucket) begin
            n_bad++;
            $display("FAIL d3_bucket: bucket_empty=%0d, expected %0d", dut.bucket_empty_time, exp_bucket);
        end
        pop_out();
    endtask

    task automatic test_backpressure();
        int unsigned lat;
        logic [TW-1:0] tp;
        set_timer(72'd250_000_000);
        send_desc(16'd64, 72'd200_000_000);
        wait_valid(lat, tp);
        n_cmp++;
        if (lat != 5 || dif.m_desc_elig !== 72'd200_000_000 || dif.m_desc_drop !== 1'b0) begin
            n_bad++;
            $display("FAIL d4_out: lat=%0d elig=%0d drop=%b, expected 5 200000000 0",
                     lat, dif.m_desc_elig, dif.m_desc_drop);
        end
        n_cmp++;
        if (dut.bucket_empty_time !== 72'd188_512_000) begin
            n_bad++;
            $display("FAIL d4_bucket: bucket_empty=%0d, expected 188512000", dut.bucket_empty_time);
        end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (dif.m_desc_valid !== 1'b1 || dif.m_desc_elig !== 72'd200_000_000 ||
                dif.m_desc_len !== 16'd64 || dif.s_desc_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_%0d: valid=%b elig=%0d len=%0d ready=%b, expected 1 200000000 64 0",
                         i, dif.m_desc_valid, dif.m_desc_elig, dif.m_desc_len, dif.s_desc_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        pop_out();
        n_cmp++;
        if (dif.m_desc_valid !== 1'b0 || dif.s_desc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_pop: valid=%b ready=%b, expected 0 1", dif.m_desc_valid, dif.s_desc_ready);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (dif.m_desc_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_single: valid=%b after one handshake, expected 0", dif.m_desc_valid);
        end
    endtask

    task automatic test_reset_in_wait();
        int unsigned lat;
        logic [TW-1:0] tp;
        set_timer(72'd0);
        send_desc(16'd64, 72'd300_000_000);
        repeat (6) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (dif.m_desc_valid !== 1'b0 || dif.s_desc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_wait_ctrl: valid=%b ready=%b, expected 0 1", dif.m_desc_valid, dif.s_desc_ready);
        end
        n_cmp++;
        if (dut.bucket_empty_time !== '0 || dut.group_elig_time !== '0) begin
            n_bad++;
            $display("FAIL rst_wait_state: bucket_empty=%0d group=%0d, expected 0 0",
                     dut.bucket_empty_time, dut.group_elig_time);
        end
        @(negedge clk);
        set_timer(72'd1_000_000);
        send_desc(16'd64, 72'd0);
        wait_valid(lat, tp);
        n_cmp++;
        if (lat != 5 || dif.m_desc_elig !== 72'd512_000 || dif.m_desc_drop !== 1'b0) begin
            n_bad++;
            $display("FAIL post_rst_desc: lat=%0d elig=%0d drop=%b, expected 5 512000 0",
                     lat, dif.m_desc_elig, dif.m_desc_drop);
        end
        pop_out();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_min_latency();
        test_wait_release();
        test_third_desc();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ats_eligibility_scheduler.md
# ats_eligibility_scheduler

Per-stream ATS (IEEE 802.1Qcr) token-bucket eligibility scheduler. It sits downstream of the timestamp-stamping stage. It consumes one frame descriptor per frame: byte length plus the arrival timestamp taken from the ATS scheduler timer. For each descriptor it computes the eligibility time, holds the descriptor until the shared `ats_scheduler_timer` reaches that time, then releases it to the transmit selection logic.

## Interface
- `TIMESTAMP_WIDTH`, 72, timestamp/timer width in ps
- `FRAME_LENGTH_WIDTH`, 16, frame length width in bytes
- `RATE_WIDTH`, 24, width of ps-per-byte rate config
- `BURST_WIDTH`, 24, width of burst-size config (bytes)

- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `ats_scheduler_timer` in TIMESTAMP_WIDTH: free-running ps timer.
- `cfg_ps_per_byte` in RATE_WIDTH: committed rate, in ps per byte (8000 = 1 Gb/s).
- `cfg_burst_bytes` in BURST_WIDTH: committed burst size.
- `cfg_max_residence` in TIMESTAMP_WIDTH: max residence time, in ps.
- `s_desc_len` in FRAME_LENGTH_WIDTH: frame length.
- `s_desc_arrival` in TIMESTAMP_WIDTH: arrival timestamp.
- `s_desc_valid` in 1 / `s_desc_ready` out 1: input handshake.
- `m_desc_len` out FRAME_LENGTH_WIDTH: passed-through length.
- `m_desc_elig` out TIMESTAMP_WIDTH: computed eligibility time.
- `m_desc_drop` out 1: 1 = frame must be discarded.
- `m_desc_valid` out 1 / `m_desc_ready` in 1: output handshake.

## Operation
- State registers, both reset to 0: `bucket_empty_time`, `group_elig_time`.
- Config ports are sampled on the input handshake cycle and held for that descriptor.
- FSM states: IDLE, MUL, ELIG, DECIDE, WAIT, OUT. Reset enters IDLE.
- IDLE: `s_desc_ready`=1. On valid&ready, latch the descriptor and config, then go to MUL.
- MUL: `len_dur = len * ps_per_byte` and `e2f_dur = burst * ps_per_byte`. Both products are zero-extended to TIMESTAMP_WIDTH. Go to ELIG.
- ELIG: `sched_elig = bucket_empty_time + len_dur` and `bucket_full = bucket_empty_time + e2f_dur`. `elig = max(arrival, group_elig_time, sched_elig)`. Go to DECIDE.
- DECIDE, pass case: `group_elig_time <= elig`. If `elig < bucket_full`, `bucket_empty_time <= sched_elig`; otherwise `bucket_empty_time <= sched_elig + elig - bucket_full`. Go to WAIT.
- DECIDE, drop case (see Configuration): state is unchanged, `drop`=1, go directly to OUT.
- WAIT: when `ats_scheduler_timer >= elig`, go to OUT.
- OUT: `m_desc_valid`=1. Outputs are registered and stable until `m_desc_ready`. On the handshake, go to IDLE.
- All arithmetic is unsigned modulo 2^TIMESTAMP_WIDTH. There is no timer wrap handling (72-bit ps wrap is out of scope).
- If `cfg_ps_per_byte`=0, `elig = max(arrival, group_elig_time)`.

## Timing
- Reset values: `s_desc_ready`=0 while `rst`=1 (1 in IDLE after reset); `m_desc_valid`=0, `m_desc_drop`=0, `m_desc_len`=0, `m_desc_elig`=0.
- Input handshake at cycle T: MUL at T+1, ELIG at T+2, DECIDE at T+3, WAIT from T+4.
- If the timer is already ≥ `elig` at T+4, `m_desc_valid` rises at T+5. This is the minimum pass latency.
- A dropped descriptor has `m_desc_valid` at T+4.
- `m_desc_valid` never deasserts without `m_desc_ready`. Back-to-back: next `s_desc_ready` is in the cycle after the output handshake.
- The timer comparison uses the timer value sampled in the WAIT cycle. Release is exactly one cycle after the first cycle with `timer >= elig`.
- Simultaneous `rst` and any handshake: reset wins, the descriptor is lost, and the state registers clear.
- Reset mid-WAIT/OUT: return to IDLE, no output.

## Configuration
- `ATS_SCHEDULER_DROP_EN` defined:
  - In DECIDE, if `elig > arrival + cfg_max_residence`, the descriptor is dropped (`m_desc_drop`=1, `m_desc_elig`=elig, state registers untouched, no wait).
- Not defined:
  - The residence check and `cfg_max_residence` logic are not compiled.
  - `m_desc_drop` is tied to 0 and every descriptor takes the pass path.

## Test plan
Config for all cases: `cfg_ps_per_byte`=8000, `cfg_burst_bytes`=1500, timer +8000 per cycle, fresh reset.
- Single 64 B descriptor, arrival 100,000,000 -> `m_desc_elig`=100,000,000, drop=0. Internal `bucket_empty_time` becomes 88,512,000.
- Continuing with a 1500 B descriptor, arrival 100,000,000 -> elig 100,512,000. Valid rises one cycle after the timer first reaches ≥100,512,000. `bucket_empty_time`=100,512,000.
- Continuing with a 64 B descriptor, arrival 100,000,000 -> elig 101,024,000, `bucket_empty_time`=101,024,000 (elig < bucket_full branch).
- With `ATS_SCHEDULER_DROP_EN` and `cfg_max_residence`=800,000, the same three descriptors -> first two pass as above. Third has drop=1 with valid at T+4, and the state is unchanged: a following 64 B descriptor at arrival 200,000,000 reports elig 200,000,000.
- Backpressure: hold `m_desc_ready`=0 for 50 cycles in OUT -> outputs stable, `s_desc_ready`=0 throughout. Release ready -> one handshake, then IDLE.
- Assert `rst` during WAIT -> next cycle `m_desc_valid`=0 and IDLE. A subsequent 64 B descriptor at arrival 0 gives elig 512,000.
